// File: rtl/snake_row_scanner.sv
// Scans the snake segment list once per display row, building a column bitmap
// that is double-buffered into a display copy read by a one-cycle pixel stage.
module snake_row_scanner #(
  parameter int unsigned X        = 6,
  parameter int unsigned Y        = 5,
  parameter int unsigned S_ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [Y-1:0]        row_y,
  output logic [S_ADDR_W-1:0] q_addr,
  input  logic [X-1:0]        q_x,
  input  logic [Y-1:0]        q_y,
  input  logic                q_vld,
  input  logic [X-1:0]        fx,
  input  logic [Y-1:0]        fy,
  input  logic                pix_en,
  input  logic [X-1:0]        col_x,
  output logic                pix_head,
  output logic                pix_body,
  output logic                pix_food,
  output logic                busy,
  output logic                ovr
);

  localparam int unsigned COLS = 1 << X;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] SWAP = 2'd2;
  localparam logic [S_ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]      state;
  logic [1:0]      state_n;
  logic            start;
  logic            record;
  logic            inc;
  logic            swap;
  logic            ovr_n;

  logic [Y-1:0]    row;
  logic [COLS-1:0] build;
  logic [X-1:0]    bhead_col;
  logic            bhead_flag;
  logic [COLS-1:0] disp;
  logic [X-1:0]    dhead_col;
  logic            dhead_flag;
  logic [X-1:0]    food_col;
  logic            food_flag;

  logic            hit_head;
  logic            hit_body;
  logic            hit_food;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and control strobes
  always_comb begin
    state_n = state;
    start   = 1'b0;
    record  = 1'b0;
    inc     = 1'b0;
    swap    = 1'b0;
    ovr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) begin
          start   = 1'b1;
          state_n = SCAN;
        end
      end
      SCAN: begin
        ovr_n = line_start;
        if (q_vld) begin
          record = (q_y == row);
          // The last address ends the scan instead of wrapping back to the head.
          if (q_addr == ADDR_MAX) state_n = SWAP;
          else                    inc     = 1'b1;
        end else begin
          state_n = SWAP;
        end
      end
      SWAP: begin
        ovr_n   = line_start;
        swap    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Build and display buffers, scan address, status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_addr     <= '0;
      row        <= '0;
      build      <= '0;
      bhead_col  <= '0;
      bhead_flag <= 1'b0;
      disp       <= '0;
      dhead_col  <= '0;
      dhead_flag <= 1'b0;
      food_col   <= '0;
      food_flag  <= 1'b0;
      busy       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (start) begin
        row        <= row_y;
        build      <= '0;
        bhead_flag <= 1'b0;
        q_addr     <= '0;
      end
      if (record) begin
        build[q_x] <= 1'b1;
        if (q_addr == '0) begin
          bhead_col  <= q_x;
          bhead_flag <= 1'b1;
        end
      end
      if (inc) q_addr <= q_addr + S_ADDR_W'(1);
      if (swap) begin
        disp       <= build;
        dhead_col  <= bhead_col;
        dhead_flag <= bhead_flag;
        food_flag  <= (fy == row);
        food_col   <= fx;
        q_addr     <= '0;
      end
      busy <= (state_n != IDLE);
      ovr  <= ovr_n;
    end
  end

  // Pixel classification with head > body > food priority
  always_comb begin
    hit_head = pix_en && dhead_flag && (col_x == dhead_col);
    hit_body = pix_en && !hit_head && disp[col_x];
    hit_food = pix_en && !hit_head && !hit_body && food_flag && (col_x == food_col);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_head <= 1'b0;
      pix_body <= 1'b0;
      pix_food <= 1'b0;
    end else begin
      pix_head <= hit_head;
      pix_body <= hit_body;
      pix_food <= hit_food;
    end
  end

endmodule
